// File: rtl/cmp_ctrl.sv
// MIX compare sequencer (CMPA, CMP1..CMP6, CMPX).
// Fetches the operand, extracts fields, drives cmp, records CI.
module cmp_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [5:0]        op,
   input  logic [5:0]        field,
   input  logic [ADDR_W-1:0] m,
   input  logic [30:0]       rega,
   input  logic [30:0]       regx,
   input  logic [77:0]       regi,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [30:0]       mem_data,
   input  logic              mem_ready,
   output logic              cmp_start,
   output logic [30:0]       cmp_in1,
   output logic [30:0]       cmp_in2,
   input  logic              cmp_stop,
   input  logic              cmp_greater,
   input  logic              cmp_less,
   input  logic              cmp_equal,
   output logic              busy,
   output logic              stop,
   output logic              err,
   output logic              ci_less,
   output logic              ci_equal,
   output logic              ci_greater
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CMP, S_WAIT, S_DONE
   } state_t;

   localparam logic [2:0] CI_L = 3'b100;
   localparam logic [2:0] CI_E = 3'b010;
   localparam logic [2:0] CI_G = 3'b001;

   state_t            state_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_rd_q;
   logic              cmp_start_q;
   logic [30:0]       cmp_in1_q;
   logic [30:0]       cmp_in2_q;
   logic              stop_q;
   logic              err_q;
   logic [2:0]        ci_q;
   logic [30:0]       reg_q;
   logic [2:0]        l_q;
   logic [2:0]        r_q;
   logic [7:0]        cnt_q;

   logic [30:0]       reg_d;
   logic              valid_d;
   logic [30:0]       fld1_d;
   logic [30:0]       fld2_d;
   logic [12:0]       ri_sel;

   // Field (L:R) of a MIX word, magnitude right-justified; sign only if L=0.
   function automatic logic [30:0] fext(
      input logic [30:0] w,
      input logic [2:0]  l,
      input logic [2:0]  r
   );
      logic [2:0]  lp;
      logic [30:0] mk;
      logic [29:0] sh;
      int          nb;
      lp = (l == 3'd0) ? 3'd1 : l;
      nb = int'(r) - int'(lp) + 1;
      mk = (31'd1 << (6 * nb)) - 31'd1;
      sh = w[29:0] >> (6 * (5 - int'(r)));
      return {(l == 3'd0) ? w[30] : 1'b0, sh & mk[29:0]};
   endfunction

   // Register select and command validity for the issuing cycle.
   always_comb begin
      ri_sel  = regi[13*int'(op[2:0])-13 +: 13];
      reg_d   = {ri_sel[12], 18'd0, ri_sel[11:0]};
      if (op[2:0] == 3'd0) reg_d = rega;
      if (op[2:0] == 3'd7) reg_d = regx;
      valid_d = (op[5:3] == 3'b111) &&
                (field[5:3] <= field[2:0]) &&
                (field[2:0] <= 3'd5);
      fld1_d  = fext(reg_q, l_q, r_q);
      fld2_d  = fext(mem_data, l_q, r_q);
   end

   // Command sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         cmp_start_q <= 1'b0;
         cmp_in1_q   <= '0;
         cmp_in2_q   <= '0;
         stop_q      <= 1'b0;
         err_q       <= 1'b0;
         ci_q        <= CI_E;
         reg_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
      end else begin
         stop_q      <= 1'b0;
         err_q       <= 1'b0;
         cmp_start_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (valid_d) begin
                     reg_q      <= reg_d;
                     l_q        <= field[5:3];
                     r_q        <= field[2:0];
                     mem_addr_q <= m;
                     mem_rd_q   <= 1'b1;
                     cnt_q      <= '0;
                     state_q    <= S_FETCH;
                  end else begin
                     stop_q  <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  mem_rd_q    <= 1'b0;
                  cmp_in1_q   <= fld1_d;
                  cmp_in2_q   <= fld2_d;
                  cmp_start_q <= 1'b1;
                  state_q     <= S_CMP;
               end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                  mem_rd_q <= 1'b0;
                  stop_q   <= 1'b1;
                  err_q    <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_CMP: state_q <= S_WAIT;
            S_WAIT: begin
               if (cmp_stop) begin
                  if ((cmp_in1_q[29:0] == '0 && cmp_in2_q[29:0] == '0) ||
                      cmp_equal)
                     ci_q <= CI_E;
                  else if (cmp_greater)
                     ci_q <= CI_G;
                  else if (cmp_less)
                     ci_q <= CI_L;
                  else
                     ci_q <= CI_E;
                  stop_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;
   assign cmp_start  = cmp_start_q;
   assign cmp_in1    = cmp_in1_q;
   assign cmp_in2    = cmp_in2_q;
   assign busy       = (state_q != S_IDLE);
   assign stop       = stop_q;
   assign err        = err_q;
   assign ci_less    = ci_q[2];
   assign ci_equal   = ci_q[1];
   assign ci_greater = ci_q[0];

endmodule

// File: tb/tb_cmp_ctrl.sv
// Directed bench for cmp_ctrl with a behavioural cmp unit
// and a memory responder with programmable wait states.
module tb_cmp_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  op = '0;
   logic [5:0]  field = '0;
   logic [11:0] m = '0;
   logic [30:0] rega = '0;
   logic [30:0] regx = '0;
   logic [77:0] regi = '0;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [30:0] mem_data = '0;
   logic        mem_ready = 1'b0;
   logic        cmp_start;
   logic [30:0] cmp_in1;
   logic [30:0] cmp_in2;
   logic        cmp_stop = 1'b0;
   logic        cmp_greater = 1'b0;
   logic        cmp_less = 1'b0;
   logic        cmp_equal = 1'b0;
   logic        busy;
   logic        stop;
   logic        err;
   logic        ci_less;
   logic        ci_equal;
   logic        ci_greater;

   int n_chk = 0;
   int n_pass = 0;

   localparam logic [2:0] CL = 3'b100;
   localparam logic [2:0] CE = 3'b010;
   localparam logic [2:0] CG = 3'b001;

   cmp_ctrl #(.ADDR_W(12), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .field(field), .m(m), .rega(rega), .regx(regx),
      .regi(regi), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .mem_ready(mem_ready),
      .cmp_start(cmp_start), .cmp_in1(cmp_in1),
      .cmp_in2(cmp_in2), .cmp_stop(cmp_stop),
      .cmp_greater(cmp_greater), .cmp_less(cmp_less),
      .cmp_equal(cmp_equal), .busy(busy), .stop(stop),
      .err(err), .ci_less(ci_less), .ci_equal(ci_equal),
      .ci_greater(ci_greater)
   );

   always #5 clk = ~clk;

   // Signed order of a MIX value where -0 sorts below +0.
   function automatic longint key(input logic [30:0] x);
      longint v;
      v = 2 * longint'(x[29:0]);
      return x[30] ? -v - 1 : v;
   endfunction

   // Behavioural cmp: answers one cycle after cmp_start.
   always @(posedge clk) begin
      cmp_stop    <= cmp_start;
      cmp_greater <= key(cmp_in1) >  key(cmp_in2);
      cmp_less    <= key(cmp_in1) <  key(cmp_in2);
      cmp_equal   <= key(cmp_in1) == key(cmp_in2);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic logic [2:0] ci();
      return {ci_less, ci_equal, ci_greater};
   endfunction

   task automatic run(input string tag,
                      input logic [5:0] o, input logic [5:0] f,
                      input logic [30:0] ra, input logic [30:0] rx,
                      input logic [77:0] ri, input logic [30:0] mw,
                      input int waits, input int restart,
                      input int e_cyc, input int e_rd,
                      input logic e_err, input logic [2:0] e_ci,
                      input bit chk_in,
                      input logic [30:0] e1, input logic [30:0] e2);
      int first, rdn, nst;
      logic er;
      logic [11:0] adr;
      logic [30:0] g1, g2;
      first = -1; rdn = 0; nst = 0; er = 1'b0;
      adr = '0; g1 = '0; g2 = '0;
      @(negedge clk);
      start = 1'b1; op = o; field = f; m = 12'h5A3;
      rega = ra; regx = rx; regi = ri; mem_data = mw;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = (c == restart);
         if (mem_rd) begin
            rdn++;
            adr = mem_addr;
         end
         mem_ready = mem_rd && (rdn > waits);
         if (cmp_start) begin
            g1 = cmp_in1;
            g2 = cmp_in2;
         end
         if (stop) begin
            nst++;
            if (first < 0) begin
               first = c;
               er = err;
            end
         end
      end
      mem_ready = 1'b0;
      chk({tag, ".cyc"}, first, e_cyc);
      chk({tag, ".nstop"}, nst, 1);
      chk({tag, ".err"}, er, e_err);
      chk({tag, ".rd"}, rdn, e_rd);
      chk({tag, ".ci"}, ci(), e_ci);
      if (e_rd > 0) chk({tag, ".addr"}, adr, 12'h5A3);
      if (chk_in) begin
         chk({tag, ".in1"}, g1, e1);
         chk({tag, ".in2"}, g2, e2);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.stop", stop, 0);
      chk("rst.err", err, 0);
      chk("rst.rd", mem_rd, 0);
      chk("rst.cs", cmp_start, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.in1", cmp_in1, 0);
      chk("rst.ci", ci(), CE);
      reset = 1'b0;

      run("A", 56, 5, 31'd5, 0, 0, 31'd3, 0, -1,
          4, 1, 0, CG, 1, 31'd5, 31'd3);
      run("B", 59, 5, 0, 0, 78'(13'h1000) << 26, 31'd0,
          0, -1, 4, 1, 0, CE, 1, 31'h40000000, 31'd0);
      run("C", 63, 13, 0, 31'h40000007, 0, 31'd9, 3, -1,
          7, 4, 0, CL, 1, 31'd7, 31'd9);
      run("D", 56, 0, 31'h40000009, 0, 0, 31'd9, 0, -1,
          4, 1, 0, CE, 1, 31'h40000000, 31'd0);
      run("E", 56, 36, (31'd11 << 6) | 31'd1, 0, 0,
          31'd10 << 6, 0, -1, 4, 1, 0, CG, 1, 31'd11, 31'd10);
      run("F", 56, 36, (31'd10 << 6) | 31'd1, 0, 0,
          (31'd3 << 24) | (31'd10 << 6) | 31'd50, 0, -1,
          4, 1, 0, CE, 1, 31'd10, 31'd10);
      run("G", 57, 37, 0, 0, 78'd131, 31'd132, 0, -1,
          4, 1, 0, CL, 1, 31'd131, 31'd132);
      run("H", 56, 43, 31'd5, 0, 0, 31'd3, 0, -1,
          1, 0, 1, CL, 0, 0, 0);
      run("I", 55, 5, 31'd5, 0, 0, 31'd3, 0, -1,
          1, 0, 1, CL, 0, 0, 0);
      run("J", 56, 5, 31'd5, 0, 0, 31'd3, 99, -1,
          5, 4, 1, CL, 0, 0, 0);
      run("K", 56, 5, 31'd5, 0, 0, 31'd3, 0, 2,
          4, 1, 0, CG, 1, 31'd5, 31'd3);

      @(negedge clk);
      start = 1'b1; op = 56; field = 5;
      rega = 31'h40000005; mem_data = 31'd3;
      @(negedge clk);
      start = 1'b0;
      mem_ready = mem_rd;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("L.cs", cmp_start, 1);
      @(negedge clk);
      chk("L.busy_w", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("L.busy", busy, 0);
      chk("L.ci", ci(), CE);
      chk("L.stop", stop, 0);
      chk("L.in2", cmp_in2, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("L.ci2", ci(), CE);
      chk("L.busy2", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
